l1_result_serializer: RTL and testbench

L1_RESULT_SERIALIZER -- requirements
Module: l1_result_serializer

---
 rtl/l1_pkg.sv | 15 +
 rtl/l1_lane_mux.sv | 21 ++
 rtl/l1_result_serializer.sv | 138 +++++++++++++
 tb/tb_l1_result_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/l1_pkg.sv
// Shared L1 definitions: default array geometry, lane/word widths and the
// serializer state encoding used across L1 blocks.
package l1_pkg;

  localparam int L1_DATA_WIDTH = 16;
  localparam int L1_ARRAY_SIZE = 8;
  localparam int L1_LW         = L1_DATA_WIDTH + 1;
  localparam int L1_PW         = L1_LW * L1_ARRAY_SIZE;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } l1_state_t;

endpackage

// File: rtl/l1_lane_mux.sv
// Selects one LW-bit lane out of a packed PW-bit adder-array word by index.
module l1_lane_mux
  import l1_pkg::*;
#(
  parameter int LW         = L1_LW,
  parameter int ARRAY_SIZE = L1_ARRAY_SIZE,
  parameter int SEL_W      = 3
) (
  input  logic [LW*ARRAY_SIZE-1:0] word,
  input  logic [SEL_W-1:0]         sel,
  output logic [LW-1:0]            lane
);

  always_comb begin
    lane = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (sel == SEL_W'(i)) lane = word[i*LW +: LW];
    end
  end

endmodule

// File: rtl/l1_result_serializer.sv
// Serializes a packed L1 sum word into one lane per beat, lane 0 first.
// Define L1_SERIALIZER_SKID_EN to add a one-word spare register for full throughput.
module l1_result_serializer
  import l1_pkg::*;
#(
  parameter  int DATA_WIDTH = L1_DATA_WIDTH,
  parameter  int ARRAY_SIZE = L1_ARRAY_SIZE,
  localparam int LW         = DATA_WIDTH + 1,
  localparam int PW         = LW * ARRAY_SIZE,
  localparam int LANE_W     = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PW-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LW-1:0]     out_data,
  output logic [LANE_W-1:0] out_lane,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(ARRAY_SIZE - 1);

  l1_state_t         state, state_next;
  logic [PW-1:0]     hold;
  logic [LANE_W-1:0] lane_cnt;
  logic [LW-1:0]     lane_value;
  logic              is_last, accept, beat, last_beat;

`ifdef L1_SERIALIZER_SKID_EN
  logic [PW-1:0]     spare;
  logic              spare_full;
`endif

  assign is_last   = (lane_cnt == LAST_LANE);
  assign accept    = in_valid & in_ready;
  assign beat      = out_valid & out_ready;
  assign last_beat = beat & is_last;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A last beat stays in SEND only when another word is already waiting or arriving.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SEND;
      SEND: begin
        if (last_beat) begin
`ifdef L1_SERIALIZER_SKID_EN
          state_next = (spare_full || accept) ? SEND : IDLE;
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is asserted, even if state is still SEND.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_lane  = '0;
    out_data  = '0;
    if (!reset) begin
      case (state)
        IDLE: in_ready = 1'b1;
        SEND: begin
          out_valid = 1'b1;
          out_data  = lane_value;
          out_lane  = lane_cnt;
          out_last  = is_last;
`ifdef L1_SERIALIZER_SKID_EN
          in_ready  = !spare_full;
`endif
        end
        default: in_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      lane_cnt   <= '0;
`ifdef L1_SERIALIZER_SKID_EN
      spare      <= '0;
      spare_full <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (accept) begin
        hold     <= in_data;
        lane_cnt <= '0;
      end
    end else begin
      if (beat) begin
        if (is_last) begin
          lane_cnt <= '0;
`ifdef L1_SERIALIZER_SKID_EN
          if (spare_full) begin
            hold       <= spare;
            spare_full <= 1'b0;
          end else if (accept) begin
            hold <= in_data;
          end
`endif
        end else begin
          lane_cnt <= lane_cnt + LANE_W'(1);
        end
      end
`ifdef L1_SERIALIZER_SKID_EN
      // A word landing exactly on the last beat bypasses the spare entirely.
      if (accept && !last_beat) begin
        spare      <= in_data;
        spare_full <= 1'b1;
      end
`endif
    end
  end

  l1_lane_mux #(
    .LW        (LW),
    .ARRAY_SIZE(ARRAY_SIZE),
    .SEL_W     (LANE_W)
  ) u_lane_mux (
    .word(hold),
    .sel (lane_cnt),
    .lane(lane_value)
  );

endmodule

// File: tb/tb_l1_result_serializer.sv
// Scoreboard bench for l1_result_serializer: stimulus pushes expected beats,
// a negedge monitor pops and compares every transferred or stalled beat.
module tb_l1_result_serializer;
  import l1_pkg::*;

  localparam int LW = L1_LW;
  localparam int PW = L1_PW;
  localparam int N  = L1_ARRAY_SIZE;

  typedef struct packed {
    logic [LW-1:0] data;
    logic [2:0]    lane;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] out_data;
  logic [2:0]    out_lane;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  beat_t exp_q[$];
  int    beat_cyc[$];
  int    cyc   = 0;
  int    tests = 0;
  int    fails = 0;

  l1_result_serializer dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_lane (out_lane),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Every valid beat is compared against the scoreboard head; a stalled beat must match without popping.
  always @(negedge clk) begin
    beat_t e;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_output("beat with empty scoreboard", 32'(out_valid), 32'd0);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        check_output("beat data", 32'(out_data), 32'(e.data));
        check_output("beat lane", 32'(out_lane), 32'(e.lane));
        check_output("beat last", 32'(out_last), 32'(e.last));
        beat_cyc.push_back(cyc);
      end else begin
        e = exp_q[0];
        check_output("stalled data", 32'(out_data), 32'(e.data));
        check_output("stalled lane", 32'(out_lane), 32'(e.lane));
      end
    end
  end

  function automatic logic [PW-1:0] word_inc();
    logic [PW-1:0] w;
    for (int i = 0; i < N; i++) w[i*LW +: LW] = LW'(i + 1);
    return w;
  endfunction

  function automatic logic [PW-1:0] word_const(input logic [LW-1:0] v);
    logic [PW-1:0] w;
    for (int i = 0; i < N; i++) w[i*LW +: LW] = v;
    return w;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic apply_stimulus(input logic [PW-1:0] w);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        for (int i = 0; i < N; i++) begin
          beat_t e;
          e.data = w[i*LW +: LW];
          e.lane = 3'(i);
          e.last = (i == N - 1);
          exp_q.push_back(e);
        end
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check_output("input accept timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check_output("drain leftover beats", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_output("reset in_ready", 32'(in_ready), 32'd0);
    check_output("reset out_valid", 32'(out_valid), 32'd0);
    check_output("reset out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("post-reset in_ready", 32'(in_ready), 32'd1);
    check_output("post-reset out_valid", 32'(out_valid), 32'd0);
    check_output("post-reset out_last", 32'(out_last), 32'd0);
    check_output("post-reset out_lane", 32'(out_lane), 32'd0);
    check_output("post-reset out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;

    $display("[TB] incrementing lanes");
    apply_stimulus(word_inc());
    drain();

    $display("[TB] all-ones lanes");
    apply_stimulus(word_const(17'h1FFFF));
    drain();

    $display("[TB] output stall on beats 3-5");
    apply_stimulus(word_inc());
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    drain();

    $display("[TB] back-to-back words");
    beat_cyc.delete();
    apply_stimulus(word_inc());
    apply_stimulus(word_const(17'h0A5A5));
    drain();
    check_output("back-to-back beat count", 32'(beat_cyc.size()), 32'd16);
    if (beat_cyc.size() == 16) begin
      for (int i = 1; i < 16; i++) begin
`ifdef L1_SERIALIZER_SKID_EN
        check_output("beat spacing", 32'(beat_cyc[i] - beat_cyc[i-1]), 32'd1);
`else
        check_output("beat spacing", 32'(beat_cyc[i] - beat_cyc[i-1]), (i == 8) ? 32'd2 : 32'd1);
`endif
      end
    end

    $display("[TB] reset mid-word");
    apply_stimulus(word_inc());
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    check_output("lanes pending at reset", 32'(exp_q.size()), 32'd5);
    @(negedge clk);
    check_output("mid-reset out_valid", 32'(out_valid), 32'd0);
    check_output("mid-reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_output("after mid-reset out_valid", 32'(out_valid), 32'd0);
    check_output("after mid-reset in_ready", 32'(in_ready), 32'd1);
    check_output("after mid-reset out_data", 32'(out_data), 32'd0);
    repeat (10) begin @(posedge clk); #1; end

    $display("[TB] recovery word");
    apply_stimulus(word_const(17'h00001));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
